// File: rtl/int_mem_rd_resp.sv
// Read-response stage of the AXI internal-memory slave: SRAM read issue, 2-entry response buffer, R channel.
// Optional build macro INT_MEM_RD_DECERR_EN enables the out-of-range DECERR check.
module int_mem_rd_resp #(
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned MEM_AW     = 14
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [31:0]           AddrIn,
    input  logic [ID_WIDTH-1:0]   AddrId,
    input  logic                  AddrLast,
    input  logic                  AddrValid,
    output logic                  MemCs,
    output logic [MEM_AW-1:0]     MemAddr,
    input  logic [DATA_WIDTH-1:0] MemRdData,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [ID_WIDTH-1:0]   RID,
    output logic                  RLAST,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  Overflow
);

    localparam int unsigned BO  = $clog2(DATA_WIDTH / 8);
    localparam int unsigned AHI = MEM_AW + BO;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ID_WIDTH-1:0]   id;
        logic                  last;
        logic [1:0]            resp;
    } rbeat_t;

    logic                w_oor;
    logic                w_unused_addr;
    logic                r_p1_valid;
    logic [ID_WIDTH-1:0] r_p1_id;
    logic                r_p1_last;
    logic                r_p1_err;
    rbeat_t              w_in_beat;
    rbeat_t              w_head;
    rbeat_t              r_buf [2];
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_count;
    logic [1:0]          w_count_nxt;
    logic                r_overflow;
    logic                w_rvalid;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_drop;

    // Address bits above the SRAM word (within the 1 MiB window) flag an out-of-range beat.
`ifdef INT_MEM_RD_DECERR_EN
    assign w_oor = |(AddrIn[19:0] >> AHI);
`else
    assign w_oor = 1'b0;
`endif

    assign w_unused_addr = ^{AddrIn[31:AHI], AddrIn[BO-1:0]};

    // Stage 0: one SRAM read per accepted beat.
    assign MemCs   = AddrValid & ARESETn & ~w_oor;
    assign MemAddr = AddrIn[AHI-1:BO];

    // Stage 1: beat sideband waits here while the SRAM returns data.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_p1_valid <= 1'b0;
            r_p1_id    <= '0;
            r_p1_last  <= 1'b0;
            r_p1_err   <= 1'b0;
        end else begin
            r_p1_valid <= AddrValid;
            if (AddrValid) begin
                r_p1_id   <= AddrId;
                r_p1_last <= AddrLast;
                r_p1_err  <= w_oor;
            end
        end
    end

    always_comb begin
        w_in_beat.data = r_p1_err ? '0 : MemRdData;
        w_in_beat.id   = r_p1_id;
        w_in_beat.last = r_p1_last;
        w_in_beat.resp = r_p1_err ? RESP_DECERR : RESP_OKAY;
    end

    // Buffer control: a push into a full buffer is only taken when the head leaves the same cycle.
    always_comb begin
        w_rvalid    = (r_count != 2'd0);
        w_full      = (r_count == 2'd2);
        w_pop       = w_rvalid & RREADY;
        w_push      = r_p1_valid & (~w_full | w_pop);
        w_drop      = r_p1_valid & w_full & ~w_pop;
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_count    <= 2'd0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset; outputs are masked while the buffer is empty.
    always_ff @(posedge ACLK) begin
        if (w_push) begin
            r_buf[r_wptr] <= w_in_beat;
        end
    end

    assign w_head   = r_buf[r_rptr];
    assign RVALID   = w_rvalid;
    assign RDATA    = w_rvalid ? w_head.data : '0;
    assign RID      = w_rvalid ? w_head.id   : '0;
    assign RLAST    = w_rvalid & w_head.last;
    assign RRESP    = w_rvalid ? w_head.resp : 2'b00;
    assign Overflow = r_overflow;

endmodule

// File: tb/tb_int_mem_rd_resp.sv
// Directed self-checking bench for int_mem_rd_resp (DATA_WIDTH=64, MEM_AW=14, ID_WIDTH=4).
module tb_int_mem_rd_resp;

    logic        ACLK;
    logic        ARESETn;
    logic [31:0] AddrIn;
    logic [3:0]  AddrId;
    logic        AddrLast;
    logic        AddrValid;
    logic        MemCs;
    logic [13:0] MemAddr;
    logic [63:0] MemRdData;
    logic [63:0] RDATA;
    logic [3:0]  RID;
    logic        RLAST;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY;
    logic        Overflow;

    int n_checks;
    int n_errors;

    int_mem_rd_resp #(
        .ID_WIDTH  (4),
        .DATA_WIDTH(64),
        .MEM_AW    (14)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .AddrIn   (AddrIn),
        .AddrId   (AddrId),
        .AddrLast (AddrLast),
        .AddrValid(AddrValid),
        .MemCs    (MemCs),
        .MemAddr  (MemAddr),
        .MemRdData(MemRdData),
        .RDATA    (RDATA),
        .RID      (RID),
        .RLAST    (RLAST),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .Overflow (Overflow)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    // SRAM: tagged word content; all-ones when not selected so masked data is visible.
    function automatic logic [63:0] sram_word(input logic [13:0] a);
        return {16'hDA7A, 2'b00, a, 16'hBEEF, 2'b00, a};
    endfunction

    always @(posedge ACLK) begin
        MemRdData <= MemCs ? sram_word(MemAddr) : '1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One cycle: wait for the edge, drive this cycle's inputs, let them settle.
    task automatic step(input logic rst_n, input logic rdy, input logic v,
                        input logic [31:0] a, input logic [3:0] id, input logic l);
        @(posedge ACLK);
        #1;
        ARESETn   = rst_n;
        RREADY    = rdy;
        AddrValid = v;
        AddrIn    = a;
        AddrId    = id;
        AddrLast  = l;
        #1;
    endtask

    task automatic idle(input logic rdy);
        step(1'b1, rdy, 1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        ARESETn   = 1'b0;
        RREADY    = 1'b0;
        AddrValid = 1'b0;
        AddrIn    = '0;
        AddrId    = '0;
        AddrLast  = 1'b0;
        MemRdData = '0;

        // Reset: chip select suppressed even with a beat presented
        step(1'b0, 1'b0, 1'b1, 32'h10, 4'h3, 1'b1);
        check("rst_memcs", 64'(MemCs), 64'd0);
        check("rst_rvalid", 64'(RVALID), 64'd0);
        check("rst_rdata", RDATA, 64'd0);
        check("rst_ovf", 64'(Overflow), 64'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        idle(1'b1);
        check("rst_rvalid2", 64'(RVALID), 64'd0);

        // Single beat, latency N+2
        step(1'b1, 1'b1, 1'b1, 32'h10, 4'h3, 1'b1);
        check("single_memcs", 64'(MemCs), 64'd1);
        check("single_memaddr", 64'(MemAddr), 64'd2);
        idle(1'b1);
        check("single_n1_rvalid", 64'(RVALID), 64'd0);
        idle(1'b1);
        check("single_rvalid", 64'(RVALID), 64'd1);
        check("single_rid", 64'(RID), 64'd3);
        check("single_rlast", 64'(RLAST), 64'd1);
        check("single_rresp", 64'(RRESP), 64'd0);
        check("single_rdata", RDATA, 64'hDA7A_0002_BEEF_0002);
        idle(1'b1);
        check("single_done", 64'(RVALID), 64'd0);

        // Backpressure: two beats held for 5 stall cycles, then drained back-to-back
        step(1'b1, 1'b0, 1'b1, 32'h40, 4'h5, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h48, 4'h5, 1'b1);
        idle(1'b0);
        check("bp_rvalid_first", 64'(RVALID), 64'd1);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            check("bp_stall_rvalid", 64'(RVALID), 64'd1);
            check("bp_stall_rdata", RDATA, 64'hDA7A_0008_BEEF_0008);
            check("bp_stall_rid", 64'(RID), 64'd5);
            check("bp_stall_rlast", 64'(RLAST), 64'd0);
        end
        idle(1'b1);
        check("bp_pop0_rdata", RDATA, 64'hDA7A_0008_BEEF_0008);
        check("bp_pop0_rlast", 64'(RLAST), 64'd0);
        idle(1'b1);
        check("bp_pop1_rvalid", 64'(RVALID), 64'd1);
        check("bp_pop1_rdata", RDATA, 64'hDA7A_0009_BEEF_0009);
        check("bp_pop1_rlast", 64'(RLAST), 64'd1);
        idle(1'b1);
        check("bp_empty", 64'(RVALID), 64'd0);
        check("bp_ovf", 64'(Overflow), 64'd0);

        // Full buffer with push and pop in the same cycle
        step(1'b1, 1'b0, 1'b1, 32'h80, 4'h1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h88, 4'h2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h90, 4'h3, 1'b1);
        check("pp_first_rid", 64'(RID), 64'd1);
        idle(1'b1);
        check("pp_b0_rid", 64'(RID), 64'd1);
        check("pp_b0_rdata", RDATA, 64'hDA7A_0010_BEEF_0010);
        idle(1'b1);
        check("pp_b1_rid", 64'(RID), 64'd2);
        check("pp_b1_rdata", RDATA, 64'hDA7A_0011_BEEF_0011);
        idle(1'b1);
        check("pp_b2_rid", 64'(RID), 64'd3);
        check("pp_b2_rdata", RDATA, 64'hDA7A_0012_BEEF_0012);
        check("pp_b2_rlast", 64'(RLAST), 64'd1);
        idle(1'b1);
        check("pp_empty", 64'(RVALID), 64'd0);
        check("pp_ovf", 64'(Overflow), 64'd0);

        // Overflow: third beat arrives with buffer full and no pop
        step(1'b1, 1'b0, 1'b1, 32'h100, 4'h4, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h108, 4'h5, 1'b0);
        step(1'b1, 1'b0, 1'b1, 32'h110, 4'h6, 1'b1);
        idle(1'b0);
        check("ovf_before", 64'(Overflow), 64'd0);
        idle(1'b0);
        check("ovf_set", 64'(Overflow), 64'd1);
        check("ovf_head_rid", 64'(RID), 64'd4);
        idle(1'b1);
        check("ovf_b0_rid", 64'(RID), 64'd4);
        check("ovf_b0_rdata", RDATA, 64'hDA7A_0020_BEEF_0020);
        idle(1'b1);
        check("ovf_b1_rid", 64'(RID), 64'd5);
        check("ovf_b1_rdata", RDATA, 64'hDA7A_0021_BEEF_0021);
        idle(1'b1);
        check("ovf_only2", 64'(RVALID), 64'd0);
        check("ovf_sticky", 64'(Overflow), 64'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0);
        idle(1'b0);
        check("ovf_cleared", 64'(Overflow), 64'd0);
        check("ovf_rst_rvalid", 64'(RVALID), 64'd0);

        // Mid-burst reset after the second beat of a 4-beat burst
        step(1'b1, 1'b1, 1'b1, 32'h200, 4'h7, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h208, 4'h7, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0);
        check("mid_rst_memcs", 64'(MemCs), 64'd0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            check("mid_rst_rvalid", 64'(RVALID), 64'd0);
            check("mid_rst_rdata", RDATA, 64'd0);
            check("mid_rst_ovf", 64'(Overflow), 64'd0);
        end

        // Upper address bit 17 set: DECERR when the range check is built in, aliasing otherwise
        step(1'b1, 1'b1, 1'b1, 32'h0002_0000, 4'hA, 1'b1);
`ifdef INT_MEM_RD_DECERR_EN
        check("oor_memcs", 64'(MemCs), 64'd0);
`else
        check("oor_memcs", 64'(MemCs), 64'd1);
`endif
        check("oor_memaddr", 64'(MemAddr), 64'd0);
        idle(1'b1);
        check("oor_n1_rvalid", 64'(RVALID), 64'd0);
        idle(1'b1);
        check("oor_rvalid", 64'(RVALID), 64'd1);
        check("oor_rid", 64'(RID), 64'hA);
        check("oor_rlast", 64'(RLAST), 64'd1);
`ifdef INT_MEM_RD_DECERR_EN
        check("oor_rresp", 64'(RRESP), 64'd3);
        check("oor_rdata", RDATA, 64'd0);
`else
        check("oor_rresp", 64'(RRESP), 64'd0);
        check("oor_rdata", RDATA, 64'hDA7A_0000_BEEF_0000);
`endif
        idle(1'b1);
        check("oor_done", 64'(RVALID), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
